decode_cycle: RTL and testbench

- Decode stage of the 5-stage pipelined RV32I core.
- Consumes the fetch→decode pipeline register outputs (instruction, PC, PC+4).
- Holds the 32x32 register file (write port driven from writeback), decodes control, sign-extends immediates.
- Registers everything into the decode→execute pipeline register, with flush support for taken branches/jumps.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/reg_file.sv | 38 +++
 rtl/decode_cycle.sv | 197 +++++++++++++++++++
 tb/tb_decode_cycle.sv | 121 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU control, immediate and result-source codes,
// plus the decoded control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    logic [1:0]  alu_op;
    logic        jump;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2R/1W register file: async reads with write-through, sync write, x0 hardwired to zero.
module reg_file import riscv_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic                                wr_live;

  assign wr_live = we && (wa != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         regs     <= '0;
    else if (wr_live) regs[wa] <= wd;
  end

  // Write-through lets writeback and decode share a cycle without forwarding.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (ra1 == '0)                  rd1 = '0;
    else if (wr_live && wa == ra1)  rd1 = wd;
    if (ra2 == '0)                  rd2 = '0;
    else if (wr_live && wa == ra2)  rd2 = wd;
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control/immediate decode, decode->execute register.
// Optional DECODE_ILLEGAL_EN adds a registered IllegalE flag.
module decode_cycle import riscv_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  FlushE,
  input  logic [31:0]           InstrD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [4:0]            RDW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [4:0]            RdE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                  IllegalE
`endif
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    result_src_e           result_src;
    alu_ctrl_e             alu_ctrl;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
`ifdef DECODE_ILLEGAL_EN
    logic                  illegal;
`endif
  } de_t;

  logic [6:0]            op;
  logic [2:0]            f3;
  ctrl_t                 ctrl;
  alu_ctrl_e             alu_ctrl;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  de_t                   de_d, de_q;
`ifdef DECODE_ILLEGAL_EN
  logic                  illegal;
`endif

  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  reg_file #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    ctrl = '0;
`ifdef DECODE_ILLEGAL_EN
    illegal = 1'b0;
`endif
    case (op)
      OP_LW:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_MEM; end
      OP_SW:  begin ctrl.imm_src = IMM_S; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
      OP_R:   begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
`ifdef DECODE_ILLEGAL_EN
        if (!(f3 inside {3'b000, 3'b010, 3'b110, 3'b111})) begin
          ctrl    = '0;
          illegal = 1'b1;
        end
`endif
      end
      OP_I:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = 2'b10; end
      OP_BEQ: begin ctrl.imm_src = IMM_B; ctrl.branch = 1'b1; ctrl.alu_op = 2'b01; end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        illegal = (InstrD != '0);
`endif
      end
    endcase
  end

  // funct7[5] only selects sub for R-type; I-type addi with imm[10]=1 must stay add.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl.alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (f3)
          3'b000:  alu_ctrl = (op[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (ctrl.imm_src)
      IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
    if (op == OP_R) imm32 = '0;
  end

  always_comb begin
    de_d            = '0;
    de_d.reg_write  = ctrl.reg_write;
    de_d.mem_write  = ctrl.mem_write;
    de_d.jump       = ctrl.jump;
    de_d.branch     = ctrl.branch;
    de_d.alu_src    = ctrl.alu_src;
    de_d.result_src = ctrl.result_src;
    de_d.alu_ctrl   = alu_ctrl;
    de_d.rd1        = rd1;
    de_d.rd2        = rd2;
    de_d.imm        = DATA_WIDTH'($signed(imm32));
    de_d.pc         = PCD;
    de_d.pc4        = PCPlus4D;
    de_d.rd         = InstrD[11:7];
    de_d.rs1        = Rs1D;
    de_d.rs2        = Rs2D;
`ifdef DECODE_ILLEGAL_EN
    de_d.illegal    = illegal;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        de_q <= '0;
    else if (FlushE) de_q <= '0;
    else             de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemWriteE   = de_q.mem_write;
  assign JumpE       = de_q.jump;
  assign BranchE     = de_q.branch;
  assign ALUSrcE     = de_q.alu_src;
  assign ResultSrcE  = de_q.result_src;
  assign ALUControlE = de_q.alu_ctrl;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm;
  assign PCE         = de_q.pc;
  assign PCPlus4E    = de_q.pc4;
  assign RdE         = de_q.rd;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
`ifdef DECODE_ILLEGAL_EN
  assign IllegalE    = de_q.illegal;
`endif

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: driver queues hand-computed E-stage bundles,
// a negedge monitor pops and compares them against the registered outputs.
module tb_decode_cycle;

  typedef struct packed {
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  ac;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        FlushE = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RDW = '0;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
`ifdef DECODE_ILLEGAL_EN
  logic        IllegalE;
`endif

  decode_cycle dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
`ifdef DECODE_ILLEGAL_EN
    , .IllegalE(IllegalE)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc = 32'h0000_1000;

  function automatic exp_t actual();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E};
  endfunction

  function automatic exp_t ex(input logic rw, mw, j, b, as, input logic [1:0] rs,
                              input logic [2:0] ac, input logic [31:0] rd1, rd2, imm, p,
                              input logic [4:0] rd, rs1, rs2);
    return '{rw:rw, mw:mw, j:j, b:b, as:as, rs:rs, ac:ac, rd1:rd1, rd2:rd2, imm:imm,
             pc:p, pc4:p + 32'd4, rd:rd, rs1:rs1, rs2:rs2};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) check("e_stage", actual(), sb_q.pop_front());
  end

  task automatic step(input logic [31:0] instr, input logic flush, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = flush;
    RegWriteW = we; RDW = wa; ResultW = wd;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    pc = pc + 32'd4;
  endtask

  initial begin
    // Reset held for three edges with an R-type in decode.
    for (int i = 0; i < 3; i++) step(32'h01AC89B3, 1'b0, 1'b0, 5'd0, 32'h0, '0);
    rst = 1'b1;
    // add x19,x25,x26 with x25 written back the same cycle.
    step(32'h01AC89B3, 1'b0, 1'b1, 5'd25, 32'h11, ex(1,0,0,0,0,2'b00,3'b000,32'h11,0,0,pc,19,25,26));
    step(32'h02842903, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,0,0,1,2'b01,3'b000,0,0,32'h28,pc,18,8,8));
    step(32'h016EAA23, 1'b0, 1'b0, 5'd0, 32'h0, ex(0,1,0,0,1,2'b00,3'b000,0,0,32'h14,pc,20,29,22));
    step(32'h41830A33, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,0,0,0,2'b00,3'b001,0,0,0,pc,20,6,24));
    // addi x1,x0,-1 while writeback targets x0: no write-through for x0.
    step(32'hFFF00093, 1'b0, 1'b1, 5'd0, 32'hFF, ex(1,0,0,0,1,2'b00,3'b000,0,0,32'hFFFF_FFFF,pc,1,0,31));
    // add x2,x0,x25: x0 still zero, x25 retained.
    step(32'h01900133, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,0,0,0,2'b00,3'b000,0,32'h11,0,pc,2,0,25));
    // beq x25,x0,-8
    step(32'hFE0C8CE3, 1'b0, 1'b0, 5'd0, 32'h0, ex(0,0,0,1,0,2'b00,3'b001,32'h11,0,32'hFFFF_FFF8,pc,25,25,0));
    // jal x1,+2048
    step(32'h001000EF, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,1,0,0,2'b10,3'b000,0,0,32'h800,pc,1,0,1));
    step(32'h02842903, 1'b1, 1'b0, 5'd0, 32'h0, '0);
    step(32'h02842903, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,0,0,1,2'b01,3'b000,0,0,32'h28,pc,18,8,8));
    // Unrecognised opcode bubbles control but keeps fields.
    step(32'h00000F8F, 1'b0, 1'b0, 5'd0, 32'h0, ex(0,0,0,0,0,2'b00,3'b000,0,0,0,pc,31,0,0));
    step(32'h00000000, 1'b0, 1'b0, 5'd0, 32'h0, ex(0,0,0,0,0,2'b00,3'b000,0,0,0,pc,0,0,0));
    step(32'h001000EF, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,1,0,0,2'b10,3'b000,0,0,32'h800,pc,1,0,1));
    // Asynchronous reset mid-cycle clears outputs before the next edge.
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset", actual(), '0);
    #1 rst = 1'b1;
    step(32'h01AC89B3, 1'b0, 1'b0, 5'd0, 32'h0, ex(1,0,0,0,0,2'b00,3'b000,0,0,0,pc,19,25,26));
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
